uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the existing uart_tx, using the same bit timing and CLKS_PER_BIT convention.
- Synchronises the asynchronous serial input and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first at mid-bit, checks the stop bit, then presents the byte with a one-cycle valid pulse.
- Sits between the board RX pin and the command/feedback parser.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (clock freq / baud); legal range 4..4095.
- HALF_BIT, (CLKS_PER_BIT-1)/2, derived localparam; mid-bit sample offset.

Ports:
- i_Clock  in  1  system clock; the only clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_Rx_Serial  in  1  raw serial line; asynchronous to i_Clock; idles high.
- o_Rx_DV  out  1  one-cycle pulse; o_Rx_Byte holds a new valid byte.
- o_Rx_Byte  out  8  last good received byte; held until the next o_Rx_DV.
- o_Rx_Active  out  1  high while a frame is in progress (START through STOP).
- o_Frame_Err  out  1  one-cycle pulse; stop bit sampled low.
- o_Parity_Err  out  1  one-cycle pulse; parity mismatch (see Optional Feature).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- i_rst=1 immediately forces:
  - state IDLE, counters 0, bit index 0;
  - o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Frame_Err=0, o_Parity_Err=0;
  - both synchroniser flops to 1.
- Reset mid-frame abandons the frame; no partial byte is ever emitted.
- Synchroniser: i_Rx_Serial passes through 2 flops (rx_s). All decisions use rx_s only.
- Clock counter: width $clog2(CLKS_PER_BIT)+1; cleared on every state transition.
- IDLE:
  - counter=0, index=0.
  - rx_s==0 -> START.
- START:
  - Count to HALF_BIT.
  - At HALF_BIT, rx_s==0 -> DATA with counter=0.
  - At HALF_BIT, rx_s==1 -> glitch; return to IDLE with no error and no pulse.
- DATA:
  - Count to CLKS_PER_BIT-1, then shift rx_s into shadow[index] (LSB first).
  - index<7 -> index+1, stay in DATA.
  - index==7 -> index=0, go to PARITY (macro defined) or STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1 -> o_Rx_Byte<=shadow; o_Rx_DV=1 for the next cycle only.
  - rx_s==0 -> o_Frame_Err=1 for one cycle; o_Rx_Byte unchanged; no DV.
  - Either way -> CLEANUP.
- CLEANUP:
  - Wait until rx_s==1, then -> IDLE.
  - This is the break guard: a line held low after a framing error never generates spurious frames.
- o_Rx_Active:
  - 1 from entry to START until exit from STOP.
  - Drops to 0 on a rejected glitch.
- Error and DV exclusivity:
  - o_Rx_DV and o_Frame_Err/o_Parity_Err are never high in the same cycle.
  - Any error suppresses DV.
- Back-to-back frames: a start bit arriving immediately after the stop sample is accepted, because CLEANUP exits as soon as rx_s==1 (mid stop bit).
- Latency: o_Rx_DV rises 1 cycle after the stop-bit mid-sample, i.e. 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the input falling edge (8N1).
- Unused state encodings -> IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA: count CLKS_PER_BIT-1, sample the parity bit, then -> STOP.
  - Even parity: error if ^{shadow, parity_bit} != 0.
  - On mismatch: in the STOP-sample cycle, o_Parity_Err pulses instead of o_Rx_DV; o_Rx_Byte is unchanged.
  - If the stop bit is also 0, o_Frame_Err pulses as well.
- Undefined:
  - No PARITY state; frame is 8N1.
  - o_Parity_Err tied 0; port retained so the interface is stable.

Decomposition:
- Package uart_pkg:
  - state localparams IDLE/START/DATA/PARITY/STOP/CLEANUP, 3-bit encoding;
  - even-parity function.
- Sub-module uart_rx_sync: 2-flop synchroniser, async-high reset to 1, parameter STAGES=2.

Test Plan (CLKS_PER_BIT=8 unless noted):
- Send 8N1 frame 0xA5 -> exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Rx_Active high ~9.5 bit times, no error pulses.
- 2-cycle low glitch on idle line -> no DV and no error; o_Rx_Active pulses then returns 0; state back in IDLE by cycle HALF_BIT+4.
- Frame 0x3C with stop bit 0, line held low 3 bit times then released -> one o_Frame_Err pulse, o_Rx_Byte stays 0xA5, no DV; next frame 0x11 -> DV with 0x11.
- Back-to-back 0x00 then 0xFF, no idle gap; repeat with CLKS_PER_BIT=434 -> two DV pulses, bytes 0x00 then 0xFF in order.
- Assert i_rst during data bit 4 of 0x77 (async, mid-cycle) -> all outputs 0 immediately, no DV; release, send 0x5A -> DV with 0x5A.
- With UART_RX_PARITY_EN: 0x01 with parity bit 0 -> o_Parity_Err pulse, no DV; 0x01 with parity bit 1 -> DV with 0x01.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and parity helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    // 3-bit receiver state encoding; encodings 6 and 7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } rx_state_t;

    // Even parity: returns 1 when data plus parity bit hold an odd number of ones
    function automatic logic even_parity_err(input logic [7:0] data, input logic parity_bit);
        return ^{data, parity_bit};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser bringing the asynchronous serial line into the i_Clock domain.
// Latency: STAGES cycles from input to output.
// Backpressure: none; samples every cycle, resets to the idle (high) line level.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic i_Clock,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; resets to 1 so a reset never looks like a start bit
    always_ff @(posedge i_Clock or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined): mid-bit sampling, stop check, byte + one-cycle valid.
// Latency: o_Rx_DV rises 4 + HALF_BIT + 9*CLKS_PER_BIT cycles after the line falls (one more bit with parity).
// Backpressure: none; the consumer must take o_Rx_Byte on o_Rx_DV (the byte is held until the next good frame).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    logic            rx_s;
    rx_state_t       state;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shadow;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad;
`endif

    uart_rx_sync #(.STAGES(2)) u_sync (
        .i_Clock (i_Clock),
        .i_rst   (i_rst),
        .i_d     (i_Rx_Serial),
        .o_q     (rx_s)
    );

`ifndef UART_RX_PARITY_EN
    // Port kept so the interface is identical in both builds
    assign o_Parity_Err = 1'b0;
`endif

    // Frame FSM: every decision is taken on the synchronised line; all outputs registered
    always_ff @(posedge i_Clock or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shadow      <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= 8'h00;
            o_Rx_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            // Pulses default low; they are raised only in the stop-sample cycle
            o_Rx_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state       <= START;
                        o_Rx_Active <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            // Too short to be a start bit: drop it silently
                            state       <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt         <= '0;
                        shadow[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt    <= '0;
                        parity_bad <= even_parity_err(shadow, rx_s);
                        state      <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt     <= '0;
                        state       <= CLEANUP;
                        o_Rx_Active <= 1'b0;
                        o_Frame_Err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        o_Parity_Err <= parity_bad;
                        if (rx_s && !parity_bad) begin
                            o_Rx_Byte <= shadow;
                            o_Rx_DV   <= 1'b1;
                        end
`else
                        if (rx_s) begin
                            o_Rx_Byte <= shadow;
                            o_Rx_DV   <= 1'b1;
                        end
`endif
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                CLEANUP: begin
                    // Break guard: a line stuck low after a bad stop bit must not start a frame
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random traffic against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

    localparam int CPB      = 8;
    localparam int HALF     = (CPB - 1) / 2;
    localparam int CPB_SLOW = 434;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // Line fall -> DV observed, and cycles o_Rx_Active stays high for a full frame
    localparam int LAT     = 4 + HALF + NB * CPB;
    localparam int ACT_LEN = 1 + HALF + NB * CPB;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rx_f = 1'b1;
    logic       rx_w = 1'b1;

    logic       f_dv, f_act, f_ferr, f_perr;
    logic [7:0] f_byte;
    logic       w_dv, w_act, w_ferr, w_perr;
    logic [7:0] w_byte;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock      (clk),
        .i_rst        (rst),
        .i_Rx_Serial  (rx_f),
        .o_Rx_DV      (f_dv),
        .o_Rx_Byte    (f_byte),
        .o_Rx_Active  (f_act),
        .o_Frame_Err  (f_ferr),
        .o_Parity_Err (f_perr)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_SLOW)) dut_slow (
        .i_Clock      (clk),
        .i_rst        (rst),
        .i_Rx_Serial  (rx_w),
        .o_Rx_DV      (w_dv),
        .o_Rx_Byte    (w_byte),
        .o_Rx_Active  (w_act),
        .o_Frame_Err  (w_ferr),
        .o_Parity_Err (w_perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // kind: 4 = good byte (DV); otherwise {parity_err, frame_err}
    typedef struct {
        int         kind;
        logic [7:0] b;
        int         t0;
    } ev_t;

    ev_t        exp_q[$];
    int         act_q[$];
    logic [7:0] last_byte = 8'h00;
    int         run = 0;
    logic       prev_dv = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;
    int         dv_cnt = 0, err_cnt = 0, lat_seen = 0, act_seen = 0;
    int         k_c;
    ev_t        e_c;
    logic [7:0] slow_q[$];
    int         slow_err = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Compare process: every output event must match the next expected frame outcome
    always @(negedge clk) begin
        if (rst) begin
            run     = 0;
            prev_dv = 1'b0;
            prev_fe = 1'b0;
            prev_pe = 1'b0;
        end else begin
            chk("dv_err_exclusive", int'(f_dv && (f_ferr || f_perr)), 0);
            if (f_dv || f_ferr || f_perr) begin
                k_c = f_dv ? 4 : (int'(f_perr) * 2 + int'(f_ferr));
                if (f_dv) dv_cnt++;
                else err_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_event", k_c, -1);
                end else begin
                    e_c = exp_q.pop_front();
                    chk("event_kind", k_c, e_c.kind);
                    lat_seen = cyc - e_c.t0;
                    chk("event_latency", lat_seen, LAT);
                    if (e_c.kind == 4) last_byte = e_c.b;
                end
            end
            chk("rx_byte_held", int'(f_byte), int'(last_byte));
            chk("pulse_one_cycle", int'((f_dv && prev_dv) || (f_ferr && prev_fe) || (f_perr && prev_pe)), 0);
            if (f_act) begin
                run++;
            end else if (run > 0) begin
                act_seen = run;
                if (act_q.size() == 0) chk("spurious_active", run, 0);
                else chk("active_len", run, act_q.pop_front());
                run = 0;
            end
            prev_dv = f_dv;
            prev_fe = f_ferr;
            prev_pe = f_perr;
        end
    end

    // Collect what the slow-baud instance reports
    always @(negedge clk) begin
        if (!rst) begin
            if (w_dv) slow_q.push_back(w_byte);
            if (w_ferr || w_perr) slow_err++;
        end
    end

    // Drive a line level for n clock cycles; all driving happens 1 time unit after posedge
    task automatic hold(input int sel, input logic v, input int n);
        if (sel == 0) rx_f = v;
        else rx_w = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame; for the fast line the model outcome is queued before the start bit goes out
    task automatic send(input int sel, input int cpb, input logic [7:0] b,
                        input logic flip_par, input logic stop);
        logic pbit;
        int   pe;
        ev_t  e;
        pbit = (^b) ^ flip_par;
        pe   = 0;
`ifdef UART_RX_PARITY_EN
        pe = $countones({b, pbit}) % 2;
`endif
        if (sel == 0) begin
            e.kind = (pe == 0 && stop) ? 4 : pe * 2 + (stop ? 0 : 1);
            e.b    = b;
            e.t0   = cyc;
            exp_q.push_back(e);
            act_q.push_back(ACT_LEN);
        end
        hold(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(sel, b[i], cpb);
`ifdef UART_RX_PARITY_EN
        hold(sel, pbit, cpb);
`endif
        hold(sel, stop, cpb);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] b77;
        int         r, g, dv0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dv", int'(f_dv), 0);
        chk("reset_byte", int'(f_byte), 0);
        chk("reset_active", int'(f_act), 0);
        chk("reset_ferr", int'(f_ferr), 0);
        chk("reset_perr", int'(f_perr), 0);
        rst = 1'b0;
        hold(0, 1'b1, 4);

        // Single good frame pins absolute latency and active width
        send(0, CPB, 8'hA5, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * CPB);
        chk("a5_byte", int'(f_byte), 8'hA5);
        chk("a5_dv_count", dv_cnt, 1);
`ifdef UART_RX_PARITY_EN
        chk("a5_latency", lat_seen, 87);
        chk("a5_active_len", act_seen, 84);
`else
        chk("a5_latency", lat_seen, 79);
        chk("a5_active_len", act_seen, 76);
`endif

        // Two-cycle glitch: active for HALF_BIT+1 cycles, no pulses
        act_q.push_back(1 + HALF);
        hold(0, 1'b0, 2);
        hold(0, 1'b1, HALF + 4);
        chk("glitch_active_len", act_seen, 4);
        chk("glitch_no_event", dv_cnt + err_cnt, 1);
        hold(0, 1'b1, CPB);

        // Framing error followed by a held-low line, then a good frame
        send(0, CPB, 8'h3C, 1'b0, 1'b0);
        hold(0, 1'b0, 3 * CPB);
        hold(0, 1'b1, 2 * CPB);
        chk("ferr_byte_kept", int'(f_byte), 8'hA5);
        chk("ferr_count", err_cnt, 1);
        chk("ferr_no_dv", dv_cnt, 1);
        send(0, CPB, 8'h11, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * CPB);
        chk("after_ferr_byte", int'(f_byte), 8'h11);

        // Back-to-back frames with no idle gap
        send(0, CPB, 8'h00, 1'b0, 1'b1);
        send(0, CPB, 8'hFF, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * CPB);
        chk("b2b_byte", int'(f_byte), 8'hFF);
        chk("b2b_dv_count", dv_cnt, 4);

        send(1, CPB_SLOW, 8'h00, 1'b0, 1'b1);
        send(1, CPB_SLOW, 8'hFF, 1'b0, 1'b1);
        hold(1, 1'b1, CPB_SLOW);
        chk("slow_count", slow_q.size(), 2);
        if (slow_q.size() == 2) begin
            chk("slow_byte0", int'(slow_q[0]), 8'h00);
            chk("slow_byte1", int'(slow_q[1]), 8'hFF);
        end
        chk("slow_errors", slow_err, 0);
        chk("slow_idle_active", int'(w_act), 0);

        // Asynchronous reset in the middle of data bit 4 of 0x77
        b77 = 8'h77;
        hold(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(0, b77[i], CPB);
        hold(0, b77[4], CPB / 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_active", int'(f_act), 0);
        chk("arst_byte", int'(f_byte), 0);
        chk("arst_dv", int'(f_dv), 0);
        chk("arst_ferr", int'(f_ferr), 0);
        exp_q.delete();
        act_q.delete();
        last_byte = 8'h00;
        dv0 = dv_cnt;
        rx_f = 1'b1;
        @(posedge clk);
        #1;
        hold(0, 1'b1, 2);
        rst = 1'b0;
        hold(0, 1'b1, CPB);
        send(0, CPB, 8'h5A, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * CPB);
        chk("post_reset_byte", int'(f_byte), 8'h5A);
        chk("post_reset_dv_count", dv_cnt - dv0, 1);

`ifdef UART_RX_PARITY_EN
        // 0x01 needs parity bit 1 for even parity; bit 0 is a mismatch
        send(0, CPB, 8'h01, 1'b1, 1'b1);
        hold(0, 1'b1, 2 * CPB);
        chk("parity_bad_byte_kept", int'(f_byte), 8'h5A);
        send(0, CPB, 8'h01, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * CPB);
        chk("parity_good_byte", int'(f_byte), 8'h01);
`endif

        // Random traffic: good frames, bad stops, parity flips, glitches, zero-gap runs
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                g = $urandom_range(1, HALF);
                act_q.push_back(1 + HALF);
                hold(0, 1'b0, g);
                hold(0, 1'b1, CPB);
            end else begin
                rb = 8'($urandom);
                send(0, CPB, rb, r == 2, r != 1);
                if (r == 1) begin
                    hold(0, 1'b0, $urandom_range(0, 2 * CPB));
                    hold(0, 1'b1, CPB);
                end else begin
                    hold(0, 1'b1, $urandom_range(0, 3));
                end
            end
        end

        hold(0, 1'b1, 3 * CPB);
        chk("drain_events", exp_q.size(), 0);
        chk("drain_active", act_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
